seq_logic_shift_unit: RTL and testbench

Parametrised sequential successor to the single-bit logic gates and fixed 4-bit shifter.
- Performs one operation per transaction on WIDTH-bit operands: NOT, NAND, NOR (bitwise), logical shift left/right, rotate left.
- Shifts are iterative, one bit position per clock, with a programmable amount.
- Sits between an operand source and a result sink. Both sides use valid/ready handshakes.

---
 rtl/seq_logic_shift_unit_pkg.sv | 19 +
 rtl/seq_logic_shift_unit_if.sv | 33 +++
 rtl/seq_logic_shift_unit_shift_step.sv | 36 +++
 rtl/seq_logic_shift_unit.sv | 113 +++++++++++
 tb/tb_seq_logic_shift_unit.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/seq_logic_shift_unit_pkg.sv
// Shared opcodes and FSM state encoding for seq_logic_shift_unit.
package seq_logic_shift_pkg;

    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] OP_NOT  = 3'd0;
    localparam logic [OPW-1:0] OP_NAND = 3'd1;
    localparam logic [OPW-1:0] OP_NOR  = 3'd2;
    localparam logic [OPW-1:0] OP_SHL  = 3'd3;
    localparam logic [OPW-1:0] OP_SHR  = 3'd4;
    localparam logic [OPW-1:0] OP_ROL  = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_logic_shift_unit_if.sv
// Operand/result handshake bundle.
//   master: operand source + result sink (drives in_valid/op/a/b/shamt/out_ready)
//   slave : the unit (drives in_ready/out_valid/result/zero/carry)
interface seq_logic_shift_unit_if #(
    parameter int unsigned WIDTH = 4
);
    import seq_logic_shift_pkg::*;

    localparam int unsigned SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;

    modport master (
        output in_valid, op, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, zero, carry
    );

    modport slave (
        input  in_valid, op, a, b, shamt, out_ready,
        output in_ready, out_valid, result, zero, carry
    );

endinterface

// File: rtl/seq_logic_shift_unit_shift_step.sv
// One-position shift/rotate of a WIDTH-bit word.
//   op_i      : selects SHL / SHR / ROL; any other code passes the word through
//   word_i    : current word
//   word_o    : word after one step
//   bit_out_o : bit shifted out (SHL/SHR only, 0 for ROL)
module shift_step
    import seq_logic_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [OPW-1:0]   op_i,
    input  logic [WIDTH-1:0] word_i,
    output logic [WIDTH-1:0] word_o,
    output logic             bit_out_o
);

    always_comb begin
        word_o    = word_i;
        bit_out_o = 1'b0;
        case (op_i)
            OP_SHL: begin
                word_o    = {word_i[WIDTH-2:0], 1'b0};
                bit_out_o = word_i[WIDTH-1];
            end
            OP_SHR: begin
                word_o    = {1'b0, word_i[WIDTH-1:1]};
                bit_out_o = word_i[0];
            end
            OP_ROL: begin
                word_o    = {word_i[WIDTH-2:0], word_i[WIDTH-1]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_logic_shift_unit.sv
// Sequential logic/shift unit: bitwise NOT/NAND/NOR in one cycle, shifts and
// rotate iterated one position per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the operand/result handshake bundle
module seq_logic_shift_unit
    import seq_logic_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_logic_shift_unit_if.slave bus
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] step_word;
    logic             step_bit;

    shift_step #(.WIDTH(WIDTH)) u_shift_step (
        .op_i      (op_q),
        .word_i    (result_q),
        .word_o    (step_word),
        .bit_out_o (step_bit)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            op_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            op_q        <= op_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        count_d  = count_q;
        op_d     = op_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    op_d    = bus.op;
                    carry_d = 1'b0;
                    state_d = DONE;
                    case (bus.op)
                        OP_NOT:  result_d = ~bus.a;
                        OP_NAND: result_d = ~(bus.a & bus.b);
                        OP_NOR:  result_d = ~(bus.a | bus.b);
                        OP_SHL, OP_SHR, OP_ROL: begin
                            result_d = bus.a;
                            if (bus.shamt != '0) begin
                                count_d = bus.shamt;
                                state_d = SHIFT;
                            end
                        end
                        default: result_d = '0;
                    endcase
                end
            end
            SHIFT: begin
                result_d = step_word;
                carry_d  = step_bit;
                count_d  = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags follow the next state so they are registered yet aligned
    assign in_ready_d  = (state_d == IDLE);
    assign out_valid_d = (state_d == DONE);

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    // zero only meaningful while a result is being offered
    assign bus.zero      = out_valid_q && (result_q == '0);

endmodule

// File: tb/tb_seq_logic_shift_unit.sv
module tb_seq_logic_shift_unit;
    import seq_logic_shift_pkg::*;

    localparam int unsigned WIDTH = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    seq_logic_shift_unit_if #(.WIDTH(WIDTH)) bus ();

    seq_logic_shift_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one transaction for one cycle; returns 1ns after the accept edge.
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] shamt);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.shamt    = shamt;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Full transaction with out_ready held high: latency, outputs, return to IDLE.
    task automatic run(input string tag, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [1:0] shamt,
                       input logic [3:0] exp_res, input logic exp_zero,
                       input logic exp_carry, input int exp_lat);
        int lat;
        bus.out_ready = 1'b1;
        send(op, a, b, shamt);
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
        check({tag, "_zero"}, 32'(bus.zero), 32'(exp_zero));
        check({tag, "_carry"}, 32'(bus.carry), 32'(exp_carry));
        check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_out_valid_after"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.shamt     = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        check("rst_carry", 32'(bus.carry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Logic ops, shifts, rotate, reserved op
        run("not",  OP_NOT,  4'b0101, 4'b0000, 2'd0, 4'b1010, 1'b0, 1'b0, 1);
        run("nand", OP_NAND, 4'b1111, 4'b1111, 2'd0, 4'b0000, 1'b1, 1'b0, 1);
        run("nor",  OP_NOR,  4'b0000, 4'b0000, 2'd0, 4'b1111, 1'b0, 1'b0, 1);
        run("shl3", OP_SHL,  4'b0001, 4'b0000, 2'd3, 4'b1000, 1'b0, 1'b0, 4);
        run("shl1", OP_SHL,  4'b1001, 4'b0000, 2'd1, 4'b0010, 1'b0, 1'b1, 2);
        run("rol2", OP_ROL,  4'b1001, 4'b0000, 2'd2, 4'b0110, 1'b0, 1'b0, 3);
        run("shr0", OP_SHR,  4'b1010, 4'b0000, 2'd0, 4'b1010, 1'b0, 1'b0, 1);
        run("shr2", OP_SHR,  4'b0011, 4'b0000, 2'd2, 4'b0000, 1'b1, 1'b1, 3);
        run("rsvd", 3'd6,    4'b1111, 4'b0000, 2'd0, 4'b0000, 1'b1, 1'b0, 1);

        // Backpressure: result held while inputs churn
        bus.out_ready = 1'b0;
        send(OP_NOT, 4'b0000, 4'b0000, 2'd0);
        check("bp_out_valid_first", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.a        = 4'($urandom_range(0, 15));
            bus.op       = 3'($urandom_range(0, 5));
            @(posedge clk);
            #1;
            check("bp_result", 32'(bus.result), 32'hF);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset in the middle of a shift
        send(OP_SHL, 4'b0001, 4'b0000, 2'd3);
        @(posedge clk);
        #3;
        check("mid_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_result", 32'(bus.result), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_carry", 32'(bus.carry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst_not", OP_NOT, 4'b1100, 4'b0000, 2'd0, 4'b0011, 1'b0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
